rcservo_scheduler: RTL and testbench

RCSERVO_SCHEDULER -- requirements
Module: rcservo_scheduler

---
 rtl/rcservo_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_rcservo_scheduler.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rcservo_scheduler.sv
// Four-channel RC servo pulse scheduler: channels pulse back to back once per frame,
// with per-channel widths latched from shadow positions at the start of each frame.
module rcservo_scheduler #(
    parameter int frame_ticks  = 960000,
    parameter int center_ticks = 72000,
    parameter int min_ticks    = 48000,
    parameter int max_ticks    = 96000,
    parameter int gap_ticks    = 480,
    parameter int scale_shift  = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_chan,
    input  logic signed [31:0] cmd_pos,
    output logic [3:0]         pwm,
    output logic               frame_start,
    output logic [1:0]         active_chan
);

    localparam logic [31:0] center_c   = 32'(center_ticks);
    localparam logic [31:0] min_c      = 32'(min_ticks);
    localparam logic [31:0] max_c      = 32'(max_ticks);
    localparam logic [31:0] gap_last   = 32'(gap_ticks - 1);
    localparam logic [31:0] frame_last = 32'(frame_ticks - 1);
    // Width of a channel at position 0, already clamped.
    localparam logic [31:0] reset_width =
        (center_ticks < min_ticks) ? min_c :
        (center_ticks > max_ticks) ? max_c : center_c;

    generate
        if ((4 * (max_ticks + gap_ticks) + 1 >= frame_ticks) || (gap_ticks < 1) ||
            (min_ticks < 1) || (min_ticks > max_ticks)) begin : g_param_check
            $error("rcservo_scheduler: channel pulses and gaps do not fit in one frame");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, LATCH, PULSE, GAP, WAIT} state_t;

    state_t             state_r, state_s;
    logic [1:0]         idx_r, idx_s;
    logic [31:0]        tick_r, tick_s;
    logic [31:0]        frame_r, frame_s;
    logic signed [31:0] shadow_r [4];
    logic [31:0]        width_r [4];
    logic [3:0]         pwm_r, pwm_s;
    logic               frame_start_r, frame_start_s;
    logic               cmd_ready_r, cmd_ready_s;
    logic [1:0]         active_chan_r, active_chan_s;

    // Position to pulse width: signed 33-bit sum, then clamped to the legal range.
    function automatic logic [31:0] calc_width(input logic signed [31:0] pos);
        logic signed [31:0] step;
        logic signed [32:0] sum;
        step = pos >>> scale_shift;
        sum  = $signed({1'b0, center_c}) + $signed({step[31], step});
        if (sum < $signed({1'b0, min_c})) begin
            calc_width = min_c;
        end else if (sum > $signed({1'b0, max_c})) begin
            calc_width = max_c;
        end else begin
            calc_width = sum[31:0];
        end
    endfunction

    // Next-state logic and the registered output values that go with the next state.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        tick_s  = tick_r;
        frame_s = frame_r + 32'd1;
        case (state_r)
            IDLE: begin
                frame_s = 32'd0;
                tick_s  = 32'd0;
                idx_s   = 2'd0;
                if (enable) begin
                    state_s = LATCH;
                end else begin
                    state_s = IDLE;
                end
            end
            LATCH: begin
                idx_s   = 2'd0;
                tick_s  = 32'd0;
                state_s = PULSE;
            end
            PULSE: begin
                if (tick_r == width_r[idx_r] - 32'd1) begin
                    tick_s  = 32'd0;
                    state_s = GAP;
                end else begin
                    tick_s = tick_r + 32'd1;
                end
            end
            GAP: begin
                if (tick_r == gap_last) begin
                    tick_s = 32'd0;
                    if (idx_r == 2'd3) begin
                        state_s = WAIT;
                    end else begin
                        idx_s   = idx_r + 2'd1;
                        state_s = PULSE;
                    end
                end else begin
                    tick_s = tick_r + 32'd1;
                end
            end
            WAIT: begin
                if (frame_r == frame_last) begin
                    state_s = enable ? LATCH : IDLE;
                end else begin
                    state_s = WAIT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        // The frame counter restarts on entry to LATCH so LATCH-to-LATCH is one frame.
        if (state_s == LATCH) begin
            frame_s = 32'd0;
        end else begin
            frame_s = frame_s;
        end

        if (state_s == PULSE) begin
            pwm_s = 4'b0001 << idx_s;
        end else begin
            pwm_s = 4'b0000;
        end
        if ((state_s == PULSE) || (state_s == GAP)) begin
            active_chan_s = idx_s;
        end else begin
            active_chan_s = 2'd0;
        end
        frame_start_s = (state_s == LATCH);
        cmd_ready_s   = (state_s != LATCH);
    end

    // Sequencer state, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            idx_r         <= 2'd0;
            tick_r        <= 32'd0;
            frame_r       <= 32'd0;
            pwm_r         <= 4'b0000;
            frame_start_r <= 1'b0;
            cmd_ready_r   <= 1'b0;
            active_chan_r <= 2'd0;
        end else begin
            state_r       <= state_s;
            idx_r         <= idx_s;
            tick_r        <= tick_s;
            frame_r       <= frame_s;
            pwm_r         <= pwm_s;
            frame_start_r <= frame_start_s;
            cmd_ready_r   <= cmd_ready_s;
            active_chan_r <= active_chan_s;
        end
    end

    // Shadow positions track accepted commands; active widths only change at LATCH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                shadow_r[i] <= 32'sd0;
                width_r[i]  <= reset_width;
            end
        end else begin
            if (cmd_valid && cmd_ready_r) begin
                shadow_r[cmd_chan] <= cmd_pos;
            end
            if (state_r == LATCH) begin
                for (int i = 0; i < 4; i++) begin
                    width_r[i] <= calc_width(shadow_r[i]);
                end
            end
        end
    end

    assign pwm         = pwm_r;
    assign frame_start = frame_start_r;
    assign cmd_ready   = cmd_ready_r;
    assign active_chan = active_chan_r;

endmodule

// File: tb/tb_rcservo_scheduler.sv
// Self-checking bench for rcservo_scheduler with shortened timing parameters; expected
// pulse widths come from a floor-division position model evaluated at each frame latch.
module tb_rcservo_scheduler;

    localparam int FT   = 2000;
    localparam int CT   = 300;
    localparam int MINT = 200;
    localparam int MAXT = 400;
    localparam int GAP  = 20;
    localparam int SH   = 6;

    typedef struct {
        int                 at;
        logic [1:0]         chan;
        logic signed [31:0] pos;
    } cmd_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               enable;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_chan;
    logic signed [31:0] cmd_pos;
    logic [3:0]         pwm;
    logic               frame_start;
    logic [1:0]         active_chan;

    int                 checks = 0;
    int                 errors = 0;
    int                 fcyc = 0;
    int                 drop_at = -1;
    int                 bad_ready = 0;
    logic               last_en = 1'b0;
    logic signed [31:0] m_shadow [4];
    cmd_t               plan [$];

    always #5 clk = ~clk;

    rcservo_scheduler #(
        .frame_ticks(FT), .center_ticks(CT), .min_ticks(MINT),
        .max_ticks(MAXT), .gap_ticks(GAP), .scale_shift(SH)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .cmd_chan(cmd_chan), .cmd_pos(cmd_pos),
        .pwm(pwm), .frame_start(frame_start), .active_chan(active_chan)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference width: floor(pos / 2^SH) added to the center, then clamped.
    function automatic int exp_width(input logic signed [31:0] pos);
        longint p;
        longint q;
        longint w;
        longint d;
        d = longint'(1) << SH;
        p = pos;
        if (p >= 0) q = p / d;
        else q = -((-p + d - 1) / d);
        w = CT + q;
        if (w < MINT) w = MINT;
        if (w > MAXT) w = MAXT;
        return int'(w);
    endfunction

    // Advance one clock, issuing planned commands and recording accepted writes.
    task automatic tick();
        logic acc;
        if (!cmd_valid && plan.size() > 0 && plan[0].at <= fcyc) begin
            cmd_valid = 1'b1;
            cmd_chan  = plan[0].chan;
            cmd_pos   = plan[0].pos;
            void'(plan.pop_front());
        end
        if (drop_at == fcyc) enable = 1'b0;
        acc = cmd_valid && (cmd_ready === 1'b1);
        if (acc) m_shadow[cmd_chan] = cmd_pos;
        last_en = enable;
        @(posedge clk);
        @(negedge clk);
        fcyc++;
        if (acc) cmd_valid = 1'b0;
        if (!rst && frame_start !== 1'b1 && cmd_ready !== 1'b1) bad_ready++;
    endtask

    // Called in a LATCH cycle; checks the whole frame and stops at the next latch slot.
    task automatic run_frame(input string name);
        int w [4];
        int cnt;
        int bad;
        chk({name, "_latch_strobe"}, frame_start, 1);
        chk({name, "_latch_ready"}, cmd_ready, 0);
        chk({name, "_latch_pwm"}, pwm, 0);
        for (int c = 0; c < 4; c++) w[c] = exp_width(m_shadow[c]);
        fcyc = 0;
        tick();
        chk({name, "_ready_after_latch"}, cmd_ready, 1);
        for (int c = 0; c < 4; c++) begin
            cnt = 0;
            while (pwm === (4'b0001 << c) && active_chan === 2'(c) && cnt <= MAXT) begin
                cnt++;
                tick();
            end
            chk($sformatf("%s_ch%0d_pulse", name, c), cnt, w[c]);
            cnt = 0;
            while (pwm === 4'b0000 && active_chan === 2'(c) && cnt <= GAP) begin
                cnt++;
                tick();
            end
            chk($sformatf("%s_ch%0d_gap", name, c), cnt, GAP);
        end
        bad = 0;
        while (fcyc < FT) begin
            if (pwm !== 4'b0000 || active_chan !== 2'd0 || frame_start !== 1'b0) bad++;
            tick();
        end
        chk({name, "_wait_quiet"}, bad, 0);
        chk({name, "_frame_period"}, frame_start, last_en);
        chk({name, "_ready_steady"}, bad_ready, 0);
        bad_ready = 0;
        drop_at = -1;
        foreach (plan[i]) plan[i].at = plan[i].at - FT;
    endtask

    initial begin
        int bad;
        int cnt;
        int sel;
        cmd_t c;
        rst = 1'b1;
        enable = 1'b0;
        cmd_valid = 1'b0;
        cmd_chan = 2'd0;
        cmd_pos = 32'sd0;
        for (int i = 0; i < 4; i++) m_shadow[i] = 32'sd0;

        repeat (3) tick();
        chk("reset_pwm", pwm, 0);
        chk("reset_frame_start", frame_start, 0);
        chk("reset_ready", cmd_ready, 0);
        chk("reset_chan", active_chan, 0);
        rst = 1'b0;
        tick();
        chk("ready_after_reset", cmd_ready, 1);
        chk("idle_pwm", pwm, 0);
        chk("idle_no_strobe", frame_start, 0);
        enable = 1'b1;
        tick();
        chk("first_latch", frame_start, 1);

        run_frame("nowrite");
        plan.push_back('{250, 2'd2, 32'sd1536});
        run_frame("ch2_write");
        plan.push_back('{100, 2'd1, 32'sd10000000});
        plan.push_back('{200, 2'd3, -32'sd10000000});
        run_frame("ch2_applied");
        plan.push_back('{100, 2'd0, 32'sd640});
        plan.push_back('{300, 2'd0, -32'sd640});
        plan.push_back('{FT, 2'd1, 32'sd0});
        run_frame("clamp");
        run_frame("two_writes");
        run_frame("held_write");

        for (int f = 0; f < 5; f++) begin
            cnt = $urandom_range(1, 5);
            for (int k = 0; k < cnt; k++) begin
                c.at = k * (FT / 6) + int'($urandom_range(0, FT / 8));
                c.chan = 2'($urandom_range(0, 3));
                sel = $urandom_range(0, 2);
                if (sel == 0) c.pos = int'($urandom_range(0, 8000)) - 4000;
                else if (sel == 1) c.pos = $signed($urandom());
                else c.pos = (MAXT - CT) * 64 + int'($urandom_range(0, 127)) - 64;
                plan.push_back(c);
            end
            run_frame("rand");
        end

        drop_at = exp_width(m_shadow[0]) + GAP + 5;
        run_frame("drop");
        bad = 0;
        repeat (FT) begin
            if (pwm !== 4'b0000 || frame_start !== 1'b0 || active_chan !== 2'd0 ||
                cmd_ready !== 1'b1) bad++;
            tick();
        end
        chk("idle_quiet", bad, 0);
        enable = 1'b1;
        tick();
        chk("reenable_latch", frame_start, 1);

        fcyc = 0;
        plan.push_back('{10, 2'd2, 32'sd3200});
        cnt = 0;
        while (pwm !== 4'b0100 && cnt < FT) begin
            cnt++;
            tick();
        end
        chk("reached_ch2", pwm, 4'b0100);
        repeat (3) tick();
        rst = 1'b1;
        #1;
        chk("rst_pwm", pwm, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_chan", active_chan, 0);
        cmd_valid = 1'b0;
        plan.delete();
        for (int i = 0; i < 4; i++) m_shadow[i] = 32'sd0;
        repeat (2) tick();
        rst = 1'b0;
        bad_ready = 0;
        tick();
        chk("latch_after_reset", frame_start, 1);
        run_frame("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
